// File: rtl/dw_pkg.sv
// Shared constants, FSM states and helpers for the 3x3 depthwise window generator.
package dw_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int WIN_ELEMS  = 9;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction
endpackage

// File: rtl/dw_line_bank.sv
// One row of the line buffer: single write port, three combinational column reads
// around i_x, with per-tap masking to the pad value.
module dw_line_bank #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 112,
  parameter int AW     = 7
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_x,
  input  logic [2:0]               i_mask,
  input  logic signed [DATA_W-1:0] i_pad,
  output logic [3*DATA_W-1:0]      o_taps
);
  logic signed [DATA_W-1:0] r_mem [MAX_W];
  logic [AW-1:0]            w_addr [3];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Edge addresses are clamped so masked taps never index past the array.
  always_comb begin
    w_addr[0] = (i_x == '0) ? i_x : i_x - 1'b1;
    w_addr[1] = i_x;
    w_addr[2] = (i_x == AW'(MAX_W - 1)) ? i_x : i_x + 1'b1;
  end

  always_comb begin
    o_taps = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      o_taps[k*DATA_W +: DATA_W] = i_mask[k] ? i_pad : r_mem[w_addr[k]];
    end
  end
endmodule

// File: rtl/dw_window_gen_3x3.sv
// Streaming 3x3 window generator (pad 1, stride 1/2) feeding the depthwise MAC.
// Three rotating row banks; windows are registered into a single output stage.
module dw_window_gen_3x3
  import dw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_W  = 112,
  parameter int MAX_H  = 112
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_W+1)-1:0]    cfg_w,
  input  logic [$clog2(MAX_H+1)-1:0]    cfg_h,
  input  logic                          cfg_stride2,
  input  logic signed [DATA_W-1:0]      pad_val,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W*WIN_ELEMS-1:0]   window_flat,
  output logic                          out_last
);
  localparam int WW = $clog2(MAX_W + 1);
  localparam int HW = $clog2(MAX_H + 1);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int WE = WW + 2;
  localparam int HE = HW + 2;

  state_e                       r_state;
  logic                         r_busy;
  logic                         r_done;
  logic [WW-1:0]                r_w;
  logic [HW-1:0]                r_h;
  logic                         r_s2;
  logic signed [DATA_W-1:0]     r_pad;
  logic [WW-1:0]                r_in_x;
  logic [HW-1:0]                r_in_y;
  logic [1:0]                   r_in_bank;
  logic [WW-1:0]                r_cx;
  logic [HW-1:0]                r_cy;
  logic [1:0]                   r_cy_bank;
  logic                         r_out_done;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic [DATA_W*WIN_ELEMS-1:0]  r_win;

  logic [WE-1:0]                w_cx_n, w_cx_p1, w_px;
  logic [HE-1:0]                w_cy_n, w_cy_p1, w_py, w_row_ref;
  logic                         w_last_col, w_last_row;
  logic                         w_acc, w_emit, w_load;
  logic                         w_in_ready, w_accept;
  logic [2:0]                   w_col_mask;
  logic [2:0]                   w_mask [3];
  logic [3*DATA_W-1:0]          w_taps [3];
  logic [DATA_W*WIN_ELEMS-1:0]  w_win;

  always_comb begin
    w_cx_n     = WE'(r_cx) + (r_s2 ? WE'(2) : WE'(1));
    w_cy_n     = HE'(r_cy) + (r_s2 ? HE'(2) : HE'(1));
    w_last_col = w_cx_n >= WE'(r_w);
    w_last_row = w_cy_n >= HE'(r_h);
    w_cx_p1    = WE'(r_cx) + WE'(1);
    w_cy_p1    = HE'(r_cy) + HE'(1);
    w_px       = (w_cx_p1 >= WE'(r_w)) ? WE'(r_w) - WE'(1) : w_cx_p1;
    w_py       = (w_cy_p1 >= HE'(r_h)) ? HE'(r_h) - HE'(1) : w_cy_p1;
    w_acc      = (HE'(r_in_y) > w_py) ||
                 ((HE'(r_in_y) == w_py) && (WE'(r_in_x) > w_px));
    w_emit     = (r_state == RUN) && !r_out_done && w_acc;
    w_load     = w_emit && (!r_out_valid || out_ready);
    // Row ownership follows the centre row it is moving to this cycle: the
    // retiring bank is read before the edge at which it is rewritten.
    w_row_ref  = (w_load && w_last_col) ? w_cy_n : HE'(r_cy);
    w_in_ready = (r_state == RUN) && (r_in_y < r_h) &&
                 (HE'(r_in_y) <= w_row_ref + HE'(1));
    w_accept   = in_valid && w_in_ready;
    w_col_mask = {(w_cx_p1 >= WE'(r_w)), 1'b0, (r_cx == '0)};
  end

  // Window row ky reads input row cy-1+ky, held in bank (cy-1+ky) mod 3.
  always_comb begin
    w_mask = '{default: '0};
    for (int unsigned ky = 0; ky < 3; ky++) begin
      w_mask[mod3_add(r_cy_bank, 2'((ky + 2) % 3))] =
        (((ky == 0) && (r_cy == '0)) || ((ky == 2) && (w_cy_p1 >= HE'(r_h))))
        ? 3'b111 : w_col_mask;
    end
  end

  always_comb begin
    w_win = '0;
    for (int unsigned ky = 0; ky < 3; ky++) begin
      w_win[ky*3*DATA_W +: 3*DATA_W] = w_taps[mod3_add(r_cy_bank, 2'((ky + 2) % 3))];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_bank
    dw_line_bank #(
      .DATA_W (DATA_W),
      .MAX_W  (MAX_W),
      .AW     (AW)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_accept && (r_in_bank == 2'(g))),
      .i_waddr (r_in_x[AW-1:0]),
      .i_wdata (in_pixel),
      .i_x     (r_cx[AW-1:0]),
      .i_mask  (w_mask[g]),
      .i_pad   (r_pad),
      .o_taps  (w_taps[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w         <= '0;
      r_h         <= '0;
      r_s2        <= 1'b0;
      r_pad       <= '0;
      r_in_x      <= '0;
      r_in_y      <= '0;
      r_in_bank   <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cy_bank   <= '0;
      r_out_done  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_win       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_w        <= cfg_w;
            r_h        <= cfg_h;
            r_s2       <= cfg_stride2;
            r_pad      <= pad_val;
            r_in_x     <= '0;
            r_in_y     <= '0;
            r_in_bank  <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_cy_bank  <= '0;
            r_out_done <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (r_in_x == r_w - 1'b1) begin
              r_in_x    <= '0;
              r_in_y    <= r_in_y + 1'b1;
              r_in_bank <= mod3_add(r_in_bank, 2'd1);
            end else begin
              r_in_x <= r_in_x + 1'b1;
            end
          end
          if (w_load) begin
            r_win       <= w_win;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_col && w_last_row;
            if (w_last_col) begin
              r_cx      <= '0;
              r_cy      <= HW'(w_cy_n);
              r_cy_bank <= mod3_add(r_cy_bank, r_s2 ? 2'd2 : 2'd1);
              if (w_last_row) r_out_done <= 1'b1;
            end else begin
              r_cx <= WW'(w_cx_n);
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (r_out_valid && out_ready && r_out_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign window_flat = r_win;
endmodule

// File: tb/tb_dw_window_gen_3x3.sv
// Scoreboard bench: stimulus queues model windows, a negedge monitor pops and compares.
module tb_dw_window_gen_3x3;
  localparam int DW = 8;
  localparam int MW = 112;
  localparam int MH = 112;
  localparam int WWB = $clog2(MW + 1);
  localparam int HWB = $clog2(MH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WWB-1:0]    cfg_w = '0;
  logic [HWB-1:0]    cfg_h = '0;
  logic              cfg_stride2 = 1'b0;
  logic signed [7:0] pad_val = '0;
  logic              busy, done;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_pixel = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [9*DW-1:0]   window_flat;
  logic              out_last;

  typedef struct packed {
    logic [9*DW-1:0] win;
    logic            last;
  } exp_t;

  exp_t              exp_q[$];
  logic [9*DW-1:0]   obs_q[$];
  logic [9*DW-1:0]   t1_seq[$];
  int                n_vec = 0;
  int                n_fail = 0;
  int                done_cnt = 0;
  int                rdy_mode = 0;
  int                cw, ch, cs;
  logic signed [7:0] cpad;
  logic signed [7:0] img [MW*MH];
  bit                saw_stall;

  dw_window_gen_3x3 #(.DATA_W(DW), .MAX_W(MW), .MAX_H(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_w       (cfg_w),
    .cfg_h       (cfg_h),
    .cfg_stride2 (cfg_stride2),
    .pad_val     (pad_val),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .window_flat (window_flat),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [9*DW-1:0] model_win(input int oy, input int ox);
    logic [9*DW-1:0] r;
    int y, x, rr, cc;
    r = '0;
    y = oy * cs;
    x = ox * cs;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        rr = y + ky - 1;
        cc = x + kx - 1;
        if (rr >= 0 && rr < ch && cc >= 0 && cc < cw) r[(ky*3+kx)*DW +: DW] = img[rr*cw+cc];
        else r[(ky*3+kx)*DW +: DW] = cpad;
      end
    end
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      obs_q.push_back(window_flat);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_window: got %h, expected no window", window_flat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("window", 80'(window_flat), 80'(e.win));
        check("out_last", 80'(out_last), 80'(e.last));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && done) done_cnt++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic start_frame(input int w, input int h, input int s2, input int pad);
    int oh, ow;
    cw = w;
    ch = h;
    cs = s2 ? 2 : 1;
    cpad = pad[7:0];
    obs_q.delete();
    done_cnt = 0;
    oh = (h - 1) / cs + 1;
    ow = (w - 1) / cs + 1;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        exp_q.push_back('{win: model_win(oy, ox), last: (oy == oh - 1) && (ox == ow - 1)});
      end
    end
    cfg_w = WWB'(w);
    cfg_h = HWB'(h);
    cfg_stride2 = (s2 != 0);
    pad_val = pad[7:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit rnd);
    int g;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_pixel = img[i];
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 3000) begin
        g++;
        @(negedge clk);
      end
      if (!in_ready) begin
        n_vec++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0 at pixel %0d, expected 1", i);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int cnt);
    int g;
    g = 0;
    while (done_cnt == 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 80'(done_cnt), 80'(1));
    check({name, "_queue_drained"}, 80'(exp_q.size()), 80'(0));
    check({name, "_window_count"}, 80'(obs_q.size()), 80'(cnt));
    check({name, "_busy_idle"}, 80'(busy), 80'(0));
    exp_q.delete();
  endtask

  task automatic load_ramp(input int n);
    for (int i = 0; i < n; i++) img[i] = 8'(i + 1);
  endtask

  task automatic compare_t1(input string name);
    for (int i = 0; i < 16; i++) begin
      check(name, 80'((obs_q.size() > i) ? obs_q[i] : '0), 80'((t1_seq.size() > i) ? t1_seq[i] : '1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 80'({busy, done, in_ready, out_valid, out_last, window_flat}), 80'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 4x4 stride 1
    load_ramp(16);
    start_frame(4, 4, 0, 0);
    feed(16, 1'b0);
    finish_frame("t1", 16);
    check("t1_first", 80'((obs_q.size() > 0) ? obs_q[0] : '0), 80'(pack9(0, 0, 0, 0, 1, 2, 0, 5, 6)));
    check("t1_last", 80'((obs_q.size() > 15) ? obs_q[15] : '0), 80'(pack9(11, 12, 0, 15, 16, 0, 0, 0, 0)));
    t1_seq = obs_q;

    // 2: 5x5 stride 2
    load_ramp(25);
    start_frame(5, 5, 1, 0);
    feed(25, 1'b0);
    finish_frame("t2", 9);
    check("t2_second", 80'((obs_q.size() > 1) ? obs_q[1] : '0), 80'(pack9(0, 0, 0, 2, 3, 4, 7, 8, 9)));
    check("t2_last", 80'((obs_q.size() > 8) ? obs_q[8] : '0), 80'(pack9(19, 20, 0, 24, 25, 0, 0, 0, 0)));

    // 3: 1x1 with pad -128
    img[0] = 8'sd7;
    start_frame(1, 1, 0, -128);
    feed(1, 1'b0);
    finish_frame("t3", 1);
    check("t3_window", 80'((obs_q.size() > 0) ? obs_q[0] : '0),
          80'(pack9(-128, -128, -128, -128, 7, -128, -128, -128, -128)));

    // 4: output back-pressure mid-frame
    load_ramp(16);
    start_frame(4, 4, 0, 0);
    saw_stall = 1'b0;
    fork
      feed(16, 1'b0);
      begin
        repeat (6) @(negedge clk);
        rdy_mode = 2;
        repeat (20) begin
          @(negedge clk);
          if (in_valid && !in_ready) saw_stall = 1'b1;
        end
        rdy_mode = 0;
      end
    join
    finish_frame("t4", 16);
    check("t4_in_ready_stall", 80'(saw_stall), 80'(1));
    compare_t1("t4_seq");

    // 5: 112x3 with random valid/ready
    for (int i = 0; i < 336; i++) img[i] = 8'($urandom);
    start_frame(112, 3, 0, 5);
    rdy_mode = 1;
    feed(336, 1'b1);
    finish_frame("t5", 336);
    rdy_mode = 0;

    // 6: reset mid-frame, then a fresh 4x4 frame
    load_ramp(16);
    start_frame(4, 4, 0, 0);
    feed(10, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", 80'({busy, done, in_ready, out_valid, out_last, window_flat}), 80'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_idle_after_reset", 80'({busy, in_ready, out_valid}), 80'(0));
    start_frame(4, 4, 0, 0);
    feed(16, 1'b0);
    finish_frame("t6", 16);
    compare_t1("t6_seq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
